// File: rtl/emmc_crc_lanes.sv
// emmc_crc_lanes: per-lane serial CRC engine (CRC7 on CMD, CRC16 on DAT)
// for the eMMC host, with MSB-first serial shift-out of the result.
//
// Parameters: CRC_W (7 or 16), POLY (generator without x^CRC_W term),
//             LANES (1, 4 or 8).
// Ports:
//   clk, rstn       clock, async active-low reset
//   clr             sync clear of lane registers and FSM
//   data_valid      absorb one bit per lane from data_in
//   data_in         serial bit per lane, MSB-first
//   out_start       start serial shift-out of the CRC
//   crc_out_valid   crc_out carries a CRC bit
//   crc_out         current CRC bit per lane (0 when not valid)
//   crc_done        pulse with the last shifted bit
//   busy            FSM not idle
//   crc_par         lane i register at [i*CRC_W +: CRC_W]
// Optional (EMMC_CRC_CHECK_EN defined):
//   chk             residue check request, CALC only
//   crc_err         per-lane residue error, held until chk/clr/reset
//   chk_done        pulse when a check completes
module emmc_crc_lanes #(
    parameter int unsigned      CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021,
    parameter int unsigned      LANES = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   data_valid,
    input  logic [LANES-1:0]       data_in,
    input  logic                   out_start,
    output logic                   crc_out_valid,
    output logic [LANES-1:0]       crc_out,
    output logic                   crc_done,
    output logic                   busy,
    output logic [LANES*CRC_W-1:0] crc_par
`ifdef EMMC_CRC_CHECK_EN
    ,
    input  logic                   chk,
    output logic [LANES-1:0]       crc_err,
    output logic                   chk_done
`endif
);

    localparam int unsigned CNT_W = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CRC_W - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CRC_W-1:0] r     [LANES];
    logic [CRC_W-1:0] r_shl [LANES];
    logic [CRC_W-1:0] r_abs [LANES];

    assign crc_out_valid = (state == SHIFT);
    assign busy          = (state != IDLE);

    // Shift-out reuses the plain left shift, so the registers drain
    // to zero and the next block starts clean without a clear.
    always_comb begin
        crc_par = '0;
        crc_out = '0;
        for (int i = 0; i < LANES; i++) begin
            r_shl[i] = {r[i][CRC_W-2:0], 1'b0};
            r_abs[i] = r_shl[i]
                     ^ ({CRC_W{data_in[i] ^ r[i][CRC_W-1]}} & POLY);
            crc_par[i*CRC_W +: CRC_W] = r[i];
            crc_out[i] = r[i][CRC_W-1] & crc_out_valid;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            crc_done <= 1'b0;
            for (int i = 0; i < LANES; i++) r[i] <= '0;
`ifdef EMMC_CRC_CHECK_EN
            crc_err  <= '0;
            chk_done <= 1'b0;
`endif
        end else if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            crc_done <= 1'b0;
            for (int i = 0; i < LANES; i++) r[i] <= '0;
`ifdef EMMC_CRC_CHECK_EN
            crc_err  <= '0;
            chk_done <= 1'b0;
`endif
        end else begin
            crc_done <= 1'b0;
`ifdef EMMC_CRC_CHECK_EN
            chk_done <= 1'b0;
`endif
            unique case (state)
                IDLE, CALC: begin
                    // out_start wins; a coincident data bit is dropped.
                    if (out_start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
`ifdef EMMC_CRC_CHECK_EN
                    else if (chk && state == CALC) begin
                        state    <= IDLE;
                        chk_done <= 1'b1;
                        for (int i = 0; i < LANES; i++) begin
                            crc_err[i] <= |r[i];
                            r[i]       <= '0;
                        end
                    end
`endif
                    else if (data_valid) begin
                        state <= CALC;
                        for (int i = 0; i < LANES; i++) r[i] <= r_abs[i];
                    end
                end
                SHIFT: begin
                    for (int i = 0; i < LANES; i++) r[i] <= r_shl[i];
                    cnt      <= cnt + CNT_W'(1);
                    // Registered so it lines up with the last bit.
                    crc_done <= (cnt == PRE_LAST);
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_crc_lanes.sv
// tb_emmc_crc_lanes: self-checking bench for emmc_crc_lanes, one CRC7
// single-lane instance and one CRC16 four-lane instance.
module tb_emmc_crc_lanes;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // CRC7, one lane
    logic       a_clr = 0, a_dv = 0, a_os = 0;
    logic [0:0] a_din = '0;
    logic       a_ov, a_done, a_busy;
    logic [0:0] a_out;
    logic [6:0] a_par;
    // CRC16, four lanes
    logic        b_clr = 0, b_dv = 0, b_os = 0;
    logic [3:0]  b_din = '0;
    logic        b_ov, b_done, b_busy;
    logic [3:0]  b_out;
    logic [63:0] b_par;
`ifdef EMMC_CRC_CHECK_EN
    logic       a_chk = 0, a_cdone;
    logic [0:0] a_err;
    logic       b_chk = 0, b_cdone;
    logic [3:0] b_err;
`endif

    emmc_crc_lanes #(.CRC_W(7), .POLY(7'h09), .LANES(1)) u_cmd (
        .clk(clk), .rstn(rstn), .clr(a_clr),
        .data_valid(a_dv), .data_in(a_din), .out_start(a_os),
        .crc_out_valid(a_ov), .crc_out(a_out), .crc_done(a_done),
        .busy(a_busy), .crc_par(a_par)
`ifdef EMMC_CRC_CHECK_EN
        , .chk(a_chk), .crc_err(a_err), .chk_done(a_cdone)
`endif
    );

    emmc_crc_lanes #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_dat (
        .clk(clk), .rstn(rstn), .clr(b_clr),
        .data_valid(b_dv), .data_in(b_din), .out_start(b_os),
        .crc_out_valid(b_ov), .crc_out(b_out), .crc_done(b_done),
        .busy(b_busy), .crc_par(b_par)
`ifdef EMMC_CRC_CHECK_EN
        , .chk(b_chk), .crc_err(b_err), .chk_done(b_cdone)
`endif
    );

    bit         aq[$];
    logic [3:0] bq[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC: remainder of M(x)*x^w divided by x^w + poly,
    // computed by polynomial long division over the message bits.
    function automatic logic [15:0] ref_crc(input bit q[$], input int w,
                                            input logic [15:0] poly);
        bit b[$];
        logic [15:0] rem;
        b = q;
        for (int i = 0; i < w; i++) b.push_back(1'b0);
        for (int i = 0; i < q.size(); i++) begin
            if (b[i]) begin
                b[i] = 1'b0;
                for (int j = 1; j <= w; j++) b[i+j] = b[i+j] ^ poly[w-j];
            end
        end
        rem = '0;
        for (int j = 0; j < w; j++) rem[w-1-j] = b[q.size()+j];
        return rem;
    endfunction

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) aq.push_back(v[i]);
    endtask

    task automatic a_feed();
        foreach (aq[i]) begin
            a_dv = 1'b1;
            a_din[0] = aq[i];
            tick();
        end
        a_dv = 1'b0;
        a_din = '0;
    endtask

    task automatic b_feed();
        foreach (bq[i]) begin
            b_dv = 1'b1;
            b_din = bq[i];
            tick();
        end
        b_dv = 1'b0;
        b_din = '0;
    endtask

    task automatic b_model(output logic [63:0] e);
        bit q[$];
        e = '0;
        for (int l = 0; l < 4; l++) begin
            q.delete();
            foreach (bq[i]) q.push_back(bq[i][l]);
            e[l*16 +: 16] = ref_crc(q, 16, 16'h1021);
        end
    endtask

    task automatic a_shift(input logic [6:0] e, input string tag);
        a_os = 1'b1;
        tick();
        a_os = 1'b0;
        for (int j = 0; j < 7; j++) begin
            check({tag, "_ov"}, a_ov, 1);
            check({tag, "_bit"}, a_out, e[6-j]);
            check({tag, "_done"}, a_done, j == 6);
            tick();
        end
        check({tag, "_end_ov"}, a_ov, 0);
        check({tag, "_end_busy"}, a_busy, 0);
        check({tag, "_end_par"}, a_par, 0);
        check({tag, "_end_done"}, a_done, 0);
    endtask

    task automatic b_shift(input logic [63:0] e, input bit drop,
                           input string tag);
        logic [3:0] eb;
        b_os = 1'b1;
        if (drop) begin
            b_dv = 1'b1;
            b_din = 4'($urandom);
        end
        tick();
        b_os = 1'b0;
        b_dv = 1'b0;
        for (int j = 0; j < 16; j++) begin
            for (int l = 0; l < 4; l++) eb[l] = e[l*16 + 15 - j];
            check({tag, "_ov"}, b_ov, 1);
            check({tag, "_bits"}, b_out, eb);
            check({tag, "_done"}, b_done, j == 15);
            check({tag, "_busy"}, b_busy, 1);
            // Inputs other than clr must be ignored while shifting.
            b_dv = 1'($urandom_range(0, 1));
            b_os = 1'($urandom_range(0, 1));
            b_din = 4'($urandom);
            tick();
        end
        b_dv = 1'b0;
        b_os = 1'b0;
        b_din = '0;
        check({tag, "_end_ov"}, b_ov, 0);
        check({tag, "_end_busy"}, b_busy, 0);
        check({tag, "_end_par"}, b_par, 0);
        check({tag, "_end_out"}, b_out, 0);
    endtask

    initial begin
        logic [63:0] e;
        logic [6:0]  e7;
        logic [3:0]  eb;

        // Reset state
        tick();
        check("rst_a_par", a_par, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_ov", a_ov, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_par", b_par, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_done", b_done, 0);
        rstn = 1'b1;
        tick();

        // CMD0 CRC7
        aq.delete();
        push_bits(64'h40_0000_0000, 40);
        a_feed();
        e7 = 7'(ref_crc(aq, 7, 16'h0009));
        check("cmd0_par", a_par, 7'h4A);
        check("cmd0_model", a_par, e7);
        check("cmd0_busy", a_busy, 1);
        check("cmd0_gate", a_out, 0);
        a_shift(7'h4A, "cmd0_sh");

        // CMD8 back-to-back, no clear
        aq.delete();
        push_bits(64'h48_0000_01AA, 40);
        a_feed();
        e7 = 7'(ref_crc(aq, 7, 16'h0009));
        check("cmd8_par", a_par, 7'h43);
        check("cmd8_model", a_par, e7);
        a_shift(7'h43, "cmd8_sh");

        // 4096 ones on every lane
        bq.delete();
        for (int i = 0; i < 4096; i++) bq.push_back(4'hF);
        b_feed();
        b_model(e);
        check("ones_par", b_par, {4{16'h7FA1}});
        check("ones_model", b_par, e);
        b_shift({4{16'h7FA1}}, 1'b0, "ones_sh");

        // Lane independence
        bq.delete();
        for (int i = 0; i < 4096; i++) bq.push_back(4'h1);
        b_feed();
        check("indep_par", b_par, {48'h0, 16'h7FA1});
        b_shift({48'h0, 16'h7FA1}, 1'b0, "indep_sh");

        // clr in shift cycle 5
        bq.delete();
        for (int i = 0; i < 32; i++) bq.push_back(4'($urandom));
        b_feed();
        b_model(e);
        check("clr_pre_par", b_par, e);
        b_os = 1'b1;
        tick();
        b_os = 1'b0;
        for (int j = 0; j < 6; j++) begin
            for (int l = 0; l < 4; l++) eb[l] = e[l*16 + 15 - j];
            check("clr_bits", b_out, eb);
            check("clr_done", b_done, 0);
            if (j == 5) b_clr = 1'b1;
            tick();
        end
        b_clr = 1'b0;
        check("clr_ov", b_ov, 0);
        check("clr_par", b_par, 0);
        check("clr_busy", b_busy, 0);
        check("clr_done_a", b_done, 0);
        tick();
        check("clr_done_b", b_done, 0);

        // Randomized blocks
        for (int t = 0; t < 24; t++) begin
            bit drop;
            int n;
            n = $urandom_range(1, 64);
            drop = 1'($urandom_range(0, 1));
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(4'($urandom));
            b_feed();
            b_model(e);
            check("rnd_par", b_par, e);
            check("rnd_busy", b_busy, 1);
            check("rnd_gate", b_out, 0);
            check("rnd_ov", b_ov, 0);
            b_shift(e, drop, "rnd_sh");
        end

        // Async reset mid-CALC
        a_dv = 1'b1;
        a_din = 1'b1;
        b_dv = 1'b1;
        b_din = 4'hF;
        repeat (5) tick();
        #2;
        rstn = 1'b0;
        #1;
        check("arst_a_par", a_par, 0);
        check("arst_a_busy", a_busy, 0);
        check("arst_b_par", b_par, 0);
        check("arst_b_busy", b_busy, 0);
        check("arst_b_ov", b_ov, 0);
        check("arst_b_done", b_done, 0);
        a_dv = 1'b0;
        a_din = '0;
        b_dv = 1'b0;
        b_din = '0;
        tick();
        rstn = 1'b1;
        tick();
        check("arst_post_par", b_par, 0);

`ifdef EMMC_CRC_CHECK_EN
        // Good CMD0 frame with its CRC appended
        aq.delete();
        push_bits(64'h40_0000_0000, 40);
        push_bits(64'h4A, 7);
        a_feed();
        a_chk = 1'b1;
        tick();
        a_chk = 1'b0;
        check("chk_ok_err", a_err, 0);
        check("chk_ok_done", a_cdone, 1);
        check("chk_ok_busy", a_busy, 0);
        check("chk_ok_par", a_par, 0);
        tick();
        check("chk_ok_pulse", a_cdone, 0);

        // Corrupted data bit
        aq.delete();
        push_bits(64'h40_0000_0000, 40);
        push_bits(64'h4A, 7);
        aq[5] = ~aq[5];
        a_feed();
        a_chk = 1'b1;
        tick();
        a_chk = 1'b0;
        check("chk_bad_err", a_err, 1);
        check("chk_bad_done", a_cdone, 1);
        tick();
        check("chk_bad_hold", a_err, 1);
        a_chk = 1'b1;
        tick();
        a_chk = 1'b0;
        check("chk_idle_ign", a_cdone, 0);
        check("chk_idle_hold", a_err, 1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("chk_clr_err", a_err, 0);

        // Four lanes, lane 2 corrupted
        bq.delete();
        for (int i = 0; i < 24; i++) bq.push_back(4'($urandom));
        b_model(e);
        for (int j = 0; j < 16; j++) begin
            for (int l = 0; l < 4; l++) eb[l] = e[l*16 + 15 - j];
            bq.push_back(eb);
        end
        bq[3][2] = ~bq[3][2];
        b_feed();
        b_chk = 1'b1;
        tick();
        b_chk = 1'b0;
        check("chk4_err", b_err, 4'b0100);
        check("chk4_done", b_cdone, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
